// File: rtl/seg_display_driver.sv
// Segment-side display driver: captures a binary word, converts it to BCD one bit per
// clock (or passes hex nibbles through), and decodes the selected digit onto the cathodes.
module seg_display_driver #(
    parameter int IN_W = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [IN_W-1:0] value,
    input  logic            hex_mode,
    input  logic [3:0]      digit_sel,
    output logic            busy,
    output logic            overflow,
    output logic [6:0]      seg,
    output logic            dp
);

    localparam int CNT_W = $clog2(IN_W + 1);

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

    generate
        if (IN_W < 1 || IN_W > 16) begin : g_bad_width
            $error("seg_display_driver: IN_W must be 1..16 for a 4-digit display");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t            state, state_next;
    logic [IN_W-1:0]   shift_q, shift_next;
    logic [15:0]       bcd_q, bcd_next;
    logic [15:0]       bcd_adj;
    logic [CNT_W-1:0]  cnt_q, cnt_next;
    logic              mode_q, mode_next;
    logic              ovf_q, ovf_next;

    // Display register: the only state the cathode decoder looks at.
    logic [15:0]       disp_digits, disp_digits_next;
    logic              disp_hex, disp_hex_next;
    logic              disp_ovf, disp_ovf_next;

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < 4; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    // NOTE: every variable gets its hold value first, so no branch can infer a latch.
    always_comb begin
        state_next       = state;
        shift_next       = shift_q;
        bcd_next         = bcd_q;
        cnt_next         = cnt_q;
        mode_next        = mode_q;
        ovf_next         = ovf_q;
        disp_digits_next = disp_digits;
        disp_hex_next    = disp_hex;
        disp_ovf_next    = disp_ovf;

        case (state)
            IDLE: begin
                if (load) begin
                    shift_next = value;
                    mode_next  = hex_mode;
                    ovf_next   = (32'(value) > 32'd9999);
                    bcd_next   = '0;
                    cnt_next   = CNT_W'(IN_W);
                    state_next = hex_mode ? COMMIT : SHIFT;
                end
            end
            SHIFT: begin
                bcd_next   = {bcd_adj[14:0], shift_q[IN_W-1]};
                shift_next = shift_q << 1;
                cnt_next   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_next = COMMIT;
            end
            COMMIT: begin
                disp_digits_next = mode_q ? 16'(shift_q) : bcd_q;
                disp_hex_next    = mode_q;
                disp_ovf_next    = !mode_q && ovf_q;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            ovf_q       <= 1'b0;
            disp_digits <= '0;
            disp_hex    <= 1'b0;
            disp_ovf    <= 1'b0;
        end else begin
            state       <= state_next;
            shift_q     <= shift_next;
            bcd_q       <= bcd_next;
            cnt_q       <= cnt_next;
            mode_q      <= mode_next;
            ovf_q       <= ovf_next;
            disp_digits <= disp_digits_next;
            disp_hex    <= disp_hex_next;
            disp_ovf    <= disp_ovf_next;
        end
    end

    assign busy     = (state != IDLE);
    assign overflow = disp_ovf;
    assign dp       = 1'b1;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    logic [1:0] sel_idx;
    logic       sel_ok;
    logic [3:0] sel_nib;
    logic [3:0] lead_zero;

    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        case (digit_sel)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    // A digit is a leading zero when it and every digit above it are zero; digit0 always shows.
    always_comb begin
        lead_zero[3] = (disp_digits[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (disp_digits[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (disp_digits[7:4] == 4'd0);
        lead_zero[0] = 1'b0;
    end

    assign sel_nib = disp_digits[{sel_idx, 2'b00} +: 4];

    always_comb begin
        if (!sel_ok)
            seg = GLYPH_BLANK;
        else if (disp_ovf)
            seg = GLYPH_DASH;
        else if (!disp_hex && lead_zero[sel_idx])
            seg = GLYPH_BLANK;
        else
            seg = glyph(sel_nib);
    end

endmodule
